// File: rtl/explosion_pkg.sv
// ---------------------------------------------------------------------------
// explosion_pkg
// Purpose : shared sizing constants, the per-slot state record and a small
//           helper for the explosion scheduler slice.
// Contents: NUM_REQ / NUM_SLOTS / ANIM_FRAMES / FRAME_HOLD / REQ_W and derived
//           widths, slot_t, req_wrap_inc().
// ---------------------------------------------------------------------------
package explosion_pkg;

  localparam int NUM_REQ     = 19;  // 12 grunts, 4 escorts, 3 flagships
  localparam int NUM_SLOTS   = 4;
  localparam int ANIM_FRAMES = 8;
  localparam int FRAME_HOLD  = 4;   // frame_clk edges spent on each frame
  localparam int REQ_W       = 5;

  localparam int POS_W   = 10;
  localparam int FRAME_W = $clog2(ANIM_FRAMES);
  localparam int HOLD_W  = $clog2(FRAME_HOLD);
  localparam int SLOT_W  = $clog2(NUM_SLOTS);

  typedef struct packed {
    logic               active;
    logic [POS_W-1:0]   x;
    logic [POS_W-1:0]   y;
    logic [FRAME_W-1:0] frame;
    logic [HOLD_W-1:0]  hold;
    logic [REQ_W-1:0]   owner;
  } slot_t;

  // Requester index + 1, wrapping at NUM_REQ (used for the round-robin pointer).
  function automatic logic [REQ_W-1:0] req_wrap_inc(input logic [REQ_W-1:0] idx);
    return (idx == REQ_W'(NUM_REQ - 1)) ? '0 : idx + REQ_W'(1);
  endfunction

endpackage

// File: rtl/explosion_scheduler_if.sv
// ---------------------------------------------------------------------------
// explosion_scheduler_if
// Purpose : bundles the kill-request bus from the enemy logic and the slot
//           status bus back to the sprite renderer / enemy logic.
// Signals : clear, kill_req[19], kill_x/kill_y[19][10]      (game -> scheduler)
//           slot_active[4], slot_x/slot_y[4][10], slot_frame[4][3],
//           slot_owner[4][5], exp_busy[19]                  (scheduler -> game)
// Modports: master = game side, slave = explosion_scheduler.
// ---------------------------------------------------------------------------
interface explosion_scheduler_if
  import explosion_pkg::*;
();

  logic                              clear;
  logic [NUM_REQ-1:0]                kill_req;
  logic [NUM_REQ-1:0][POS_W-1:0]     kill_x;
  logic [NUM_REQ-1:0][POS_W-1:0]     kill_y;

  logic [NUM_SLOTS-1:0]              slot_active;
  logic [NUM_SLOTS-1:0][POS_W-1:0]   slot_x;
  logic [NUM_SLOTS-1:0][POS_W-1:0]   slot_y;
  logic [NUM_SLOTS-1:0][FRAME_W-1:0] slot_frame;
  logic [NUM_SLOTS-1:0][REQ_W-1:0]   slot_owner;
  logic [NUM_REQ-1:0]                exp_busy;

  modport master (
    output clear, kill_req, kill_x, kill_y,
    input  slot_active, slot_x, slot_y, slot_frame, slot_owner, exp_busy
  );

  modport slave (
    input  clear, kill_req, kill_x, kill_y,
    output slot_active, slot_x, slot_y, slot_frame, slot_owner, exp_busy
  );

endinterface

// File: rtl/explosion_slot.sv
// ---------------------------------------------------------------------------
// explosion_slot
// Purpose : one explosion animation slot. A load starts the animation at
//           frame 0; each frame is held FRAME_HOLD edges; after the last hold
//           of the last frame the slot frees itself.
// Ports   : frame_clk, Reset (async, active-high)
//           i_clear            flush the slot
//           i_load             start an explosion (only asserted while free)
//           i_x, i_y, i_owner  values captured on load
//           o_active, o_x, o_y, o_frame, o_owner  registered slot state
// ---------------------------------------------------------------------------
module explosion_slot
  import explosion_pkg::*;
(
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [POS_W-1:0]   i_x,
  input  logic [POS_W-1:0]   i_y,
  input  logic [REQ_W-1:0]   i_owner,
  output logic               o_active,
  output logic [POS_W-1:0]   o_x,
  output logic [POS_W-1:0]   o_y,
  output logic [FRAME_W-1:0] o_frame,
  output logic [REQ_W-1:0]   o_owner
);

  slot_t r_slot;
  logic  w_last_hold;
  logic  w_last_frame;

  assign w_last_hold  = (r_slot.hold  == HOLD_W'(FRAME_HOLD - 1));
  assign w_last_frame = (r_slot.frame == FRAME_W'(ANIM_FRAMES - 1));

  // Every field returns to zero when the slot frees, so the outputs of an
  // idle slot read 0 without any output masking.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_slot <= '0;
    end else if (i_clear) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot.active <= 1'b1;
      r_slot.x      <= i_x;
      r_slot.y      <= i_y;
      r_slot.frame  <= '0;
      r_slot.hold   <= '0;
      r_slot.owner  <= i_owner;
    end else if (r_slot.active) begin
      if (w_last_hold && w_last_frame) begin
        r_slot <= '0;
      end else if (w_last_hold) begin
        r_slot.hold  <= '0;
        r_slot.frame <= r_slot.frame + FRAME_W'(1);
      end else begin
        r_slot.hold  <= r_slot.hold + HOLD_W'(1);
      end
    end
  end

  assign o_active = r_slot.active;
  assign o_x      = r_slot.x;
  assign o_y      = r_slot.y;
  assign o_frame  = r_slot.frame;
  assign o_owner  = r_slot.owner;

endmodule

// File: rtl/explosion_scheduler.sv
// ---------------------------------------------------------------------------
// explosion_scheduler
// Purpose : queues explosion requests from 19 enemies and hands them, one per
//           frame, round-robin, to the lowest free of 4 animation slots.
// Ports   : frame_clk  one rising edge per video frame
//           Reset      asynchronous, active-high
//           bus        explosion_scheduler_if.slave (kill requests in, slot
//                      status and per-requester busy out)
// ---------------------------------------------------------------------------
module explosion_scheduler
  import explosion_pkg::*;
(
  input  logic                   frame_clk,
  input  logic                   Reset,
  explosion_scheduler_if.slave   bus
);

  logic [REQ_W-1:0]                  r_rr;

  logic [NUM_REQ-1:0]                w_pending;
  logic [NUM_REQ-1:0][POS_W-1:0]     w_lat_x;
  logic [NUM_REQ-1:0][POS_W-1:0]     w_lat_y;

  logic [NUM_SLOTS-1:0]              w_slot_active;
  logic [NUM_SLOTS-1:0][POS_W-1:0]   w_slot_x;
  logic [NUM_SLOTS-1:0][POS_W-1:0]   w_slot_y;
  logic [NUM_SLOTS-1:0][FRAME_W-1:0] w_slot_frame;
  logic [NUM_SLOTS-1:0][REQ_W-1:0]   w_slot_owner;
  logic [NUM_SLOTS-1:0]              w_load;
  logic [NUM_REQ-1:0]                w_busy;

  logic                              w_req_found;
  logic [REQ_W-1:0]                  w_req_idx;
  logic [REQ_W:0]                    w_rr_sum;
  logic                              w_free_found;
  logic [SLOT_W-1:0]                 w_free_idx;
  logic                              w_grant;

  // Round-robin search: first pending requester at or after r_rr.
  always_comb begin
    w_req_found = 1'b0;
    w_req_idx   = '0;
    w_rr_sum    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_rr_sum = {1'b0, r_rr} + (REQ_W+1)'(k);
      if (w_rr_sum >= (REQ_W+1)'(NUM_REQ)) begin
        w_rr_sum = w_rr_sum - (REQ_W+1)'(NUM_REQ);
      end
      if (!w_req_found && w_pending[w_rr_sum[REQ_W-1:0]]) begin
        w_req_found = 1'b1;
        w_req_idx   = w_rr_sum[REQ_W-1:0];
      end
    end
  end

  // Lowest free slot, judged from registered state: a slot freeing on this
  // edge is not yet visible as free, so it is only reused one edge later.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!w_slot_active[s]) begin
        w_free_found = 1'b1;
        w_free_idx   = SLOT_W'(s);
      end
    end
  end

  // clear suppresses the grant so the slots and pending bits flush together.
  assign w_grant = w_req_found && w_free_found && !bus.clear;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_rr <= '0;
    end else if (bus.clear) begin
      r_rr <= '0;
    end else if (w_grant) begin
      r_rr <= req_wrap_inc(w_req_idx);
    end
  end

  // Per-requester pending bit and coordinate latch.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic             r_pending;
    logic [POS_W-1:0] r_lat_x;
    logic [POS_W-1:0] r_lat_y;
    logic             w_granted;
    logic             w_owned;

    assign w_granted = w_grant && (w_req_idx == REQ_W'(gi));

    // A kill while pending is dropped, except on the edge this requester is
    // granted: the slot takes the old latch and the new kill re-arms pending.
    always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
        r_pending <= 1'b0;
        r_lat_x   <= '0;
        r_lat_y   <= '0;
      end else if (bus.clear) begin
        r_pending <= 1'b0;
      end else if (bus.kill_req[gi] && (!r_pending || w_granted)) begin
        r_pending <= 1'b1;
        r_lat_x   <= bus.kill_x[gi];
        r_lat_y   <= bus.kill_y[gi];
      end else if (w_granted) begin
        r_pending <= 1'b0;
      end
    end

    always_comb begin
      w_owned = 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_slot_active[s] && (w_slot_owner[s] == REQ_W'(gi))) begin
          w_owned = 1'b1;
        end
      end
    end

    assign w_pending[gi] = r_pending;
    assign w_lat_x[gi]   = r_lat_x;
    assign w_lat_y[gi]   = r_lat_y;
    assign w_busy[gi]    = r_pending | w_owned;
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    assign w_load[gi] = w_grant && (w_free_idx == SLOT_W'(gi));

    explosion_slot u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .i_clear   (bus.clear),
      .i_load    (w_load[gi]),
      .i_x       (w_lat_x[w_req_idx]),
      .i_y       (w_lat_y[w_req_idx]),
      .i_owner   (w_req_idx),
      .o_active  (w_slot_active[gi]),
      .o_x       (w_slot_x[gi]),
      .o_y       (w_slot_y[gi]),
      .o_frame   (w_slot_frame[gi]),
      .o_owner   (w_slot_owner[gi])
    );
  end

  assign bus.slot_active = w_slot_active;
  assign bus.slot_x      = w_slot_x;
  assign bus.slot_y      = w_slot_y;
  assign bus.slot_frame  = w_slot_frame;
  assign bus.slot_owner  = w_slot_owner;
  assign bus.exp_busy    = w_busy;

endmodule

// File: doc/explosion_scheduler.md
EXPLOSION_SCHEDULER -- requirements
Module: explosion_scheduler

Interface
REQ-001 frame_clk  in  1  clock; one rising edge per video frame.
REQ-002 Reset  in  1  reset, asynchronous, active-high; clock frame_clk.
REQ-003 clear  in  1  synchronous flush of all pending and active explosions (level-change/game-over).
REQ-004 kill_req  in  19  per-requester kill pulse; index 0-11 grunt enemies, 12-15 escort (es), 16-18 flagship (ef).
REQ-005 kill_x  in  19x10  per-requester X position, sampled only when its kill_req bit is 1.
REQ-006 kill_y  in  19x10  per-requester Y position, same sampling rule.
REQ-007 slot_active  out  4  slot s currently animating.
REQ-008 slot_x, slot_y  out  4x10 each  explosion centre of slot s.
REQ-009 slot_frame  out  4x3  animation frame index 0-7 of slot s.
REQ-010 slot_owner  out  4x5  requester index owning slot s (0-18).
REQ-011 exp_busy  out  19  requester i has an explosion pending or active; enemy logic holds respawn while set.

Function
REQ-012 Each requester i SHALL own a pending bit and a latched (x,y); kill_req[i]=1 sets pending and latches kill_x[i]/kill_y[i].
REQ-013 kill_req[i] while pending[i] already 1 SHALL be ignored (coordinates not overwritten).
REQ-014 Per frame_clk edge, at most one grant: round-robin over pending bits starting at pointer rr (0-18).
REQ-015 Grant only if at least one slot is free; target = lowest-index free slot.
REQ-016 On grant to i: slot loads active=1, x/y from latch, frame=0, hold=0, owner=i; pending[i] cleared; rr <= (i+1) mod 19.
REQ-017 No free slot: no grant, pending bits and rr unchanged (requests wait, never dropped).
REQ-018 Grant latency: request at edge N, earliest slot_active at edge N+1 (pending registered first).
REQ-019 Active slot: hold counter 0..3 (FRAME_HOLD=4); at hold=3, hold<=0 and frame<=frame+1.
REQ-020 At frame=7 and hold=3 the slot SHALL become free (active=0); lifetime exactly 32 edges.
REQ-021 A slot freed at edge N is grantable only at edge N+1 (free status taken from registered state).
REQ-022 Simultaneous kill_req[i] and grant of i at same edge: grant uses old latch; pending[i] re-sets with new coordinates.
REQ-023 Kill_req for a requester whose explosion is active SHALL be accepted as new pending.
REQ-024 exp_busy[i] = pending[i] OR any active slot with owner==i (combinational from registers).
REQ-025 Inactive slots SHALL drive slot_x/y/frame/owner = 0.
REQ-026 clear=1 SHALL zero all pending, slots and rr at that edge, overriding kill_req and grants.
REQ-027 Positions are passed unmodified (10-bit, no arithmetic, no wrap).

Reset
REQ-028 Reset=1 SHALL asynchronously zero: pending, latches, rr, all slot fields; all outputs read 0.
REQ-029 Reset mid-animation SHALL terminate all explosions; first grant possible at second edge after deassertion given a request at the first.

Structure
REQ-030 Package explosion_pkg SHALL hold NUM_REQ=19, NUM_SLOTS=4, ANIM_FRAMES=8, FRAME_HOLD=4, REQ_W=5, and typedef slot_t (active, x, y, frame, hold, owner).
REQ-031 Sub-module explosion_slot SHALL implement one slot (load, hold/frame counters, free), instantiated NUM_SLOTS times; arbitration and pending logic stay in explosion_scheduler.

Verification
REQ-032 Single: kill_req[5]=1, x=100, y=200 at edge 0 -> slot0 active edge 1, owner 5, (100,200); frame 1 at edge 5; free after edge 32.
REQ-033 Burst: kill_req[0..5] same edge -> grants 0,1,2,3 on edges 1-4 into slots 0-3; 4,5 wait, exp_busy[4]=exp_busy[5]=1; requester 4 granted the edge after slot0 frees.
REQ-034 Round-robin: rr=10, pending {3,12} -> 12 granted first, then 3.
REQ-035 Duplicate: kill_req[7] at (50,60) then at (70,80) while pending -> slot shows (50,60).
REQ-036 clear during 3 active slots and 2 pending -> next edge all slot_active=0, exp_busy=0.
REQ-037 Reset asserted mid-animation between edges -> outputs 0 immediately without a clock edge.
